// File: rtl/reg_writeback_queue.sv
// Register-file writeback queue: merges mem and ALU results into an in-order FIFO,
// retires one per cycle and exposes a combinational pending-write lookup for forwarding.
module reg_writeback_queue #(
  parameter int unsigned regNum  = 32,
  parameter int unsigned regSize = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [$clog2(regNum)-1:0]  mem_reg,
  input  logic [regSize-1:0]         mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [$clog2(regNum)-1:0]  alu_reg,
  input  logic [regSize-1:0]         alu_data,
  output logic                       alu_ready,
  output logic [$clog2(regNum)-1:0]  write_reg,
  output logic [regSize-1:0]         write_data,
  output logic                       reg_write,
  input  logic [$clog2(regNum)-1:0]  query_reg,
  output logic                       query_hit,
  output logic [regSize-1:0]         query_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned RW = $clog2(regNum);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [RW-1:0]      fifo_reg  [DEPTH];
  logic [regSize-1:0] fifo_data [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW-1:0]      alu_slot;
  logic               mem_push;
  logic               alu_push;
  logic               pop;

  // Readiness depends only on registered occupancy; a same-cycle pop never frees a slot.
  always_comb begin
    mem_ready = (count != DepthC);
    alu_ready = (count <= DepthC - CW'(2)) || (mem_ready && !mem_valid);
    mem_push  = mem_valid && mem_ready && (mem_reg != '0);
    alu_push  = alu_valid && alu_ready && (alu_reg != '0);
    pop       = (count != '0);
    alu_slot  = tail + PW'(mem_push);
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      fifo_reg[tail]  <= mem_reg;
      fifo_data[tail] <= mem_data;
    end
    if (alu_push) begin
      fifo_reg[alu_slot]  <= alu_reg;
      fifo_data[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      tail      <= tail + PW'(mem_push) + PW'(alu_push);
      head      <= head + PW'(pop);
      count     <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      reg_write <= pop;
      if (pop) begin
        write_reg  <= fifo_reg[head];
        write_data <= fifo_data[head];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    if (reg_write && (write_reg == query_reg)) begin
      query_hit  = 1'b1;
      query_data = write_data;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (fifo_reg[head + PW'(k)] == query_reg)) begin
        query_hit  = 1'b1;
        query_data = fifo_data[head + PW'(k)];
      end
    end
    if (query_reg == '0) begin
      query_hit  = 1'b0;
      query_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: stimulus pushes expected retires,
// a negedge monitor pops and compares whenever reg_write is presented.
module tb_reg_writeback_queue;

  localparam int unsigned RN = 32;
  localparam int unsigned RS = 32;
  localparam int unsigned D  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_reg, alu_reg, query_reg;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        query_hit;
  logic [31:0] query_data;
  logic [2:0]  count;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  mcount = 0;

  reg_writeback_queue #(.regNum(RN), .regSize(RS), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .query_reg  (query_reg),
    .query_hit  (query_hit),
    .query_data (query_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Retire monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reg_write === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL retire: got write r%0d=%0h, required no write", write_reg, write_data);
      end else begin
        e = sb.pop_front();
        if (write_reg !== e.r || write_data !== e.d) begin
          n_fail++;
          $display("FAIL retire: got r%0d=%0h, required r%0d=%0h",
                   write_reg, write_data, e.r, e.d);
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input string tag);
    logic em, ea;
    int   pushes;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    #3;
    em = (mcount < D);
    ea = (mcount + 2 <= D) || ((mcount < D) && !mv);
    chk({tag, " mem_ready"}, mem_ready, em);
    chk({tag, " alu_ready"}, alu_ready, ea);
    chk({tag, " count"}, count, mcount);
    chk({tag, " count<=DEPTH"}, (count <= D), 1);
    pushes = 0;
    if (mv && em && mr != 0) begin sb.push_back({mr, md}); pushes++; end
    if (av && ea && ar != 0) begin sb.push_back({ar, ad}); pushes++; end
    mcount = mcount + pushes - ((mcount > 0) ? 1 : 0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    query_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset reg_write", reg_write, 0);
    chk("reset write_reg", write_reg, 0);
    chk("reset write_data", write_data, 0);
    chk("reset count", count, 0);
    rst = 1'b0;

    // Single ALU write: visible only after the second edge.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, "t1");
    chk("t1 no early write", reg_write, 0);
    chk("t1 count after accept", count, 1);
    idle("t1 idle");
    chk("t1 reg_write", reg_write, 1);
    chk("t1 write_reg", write_reg, 5);
    chk("t1 write_data", write_data, 32'hDEADBEEF);
    idle("t1 drain");

    // Simultaneous mem and ALU: mem takes the older slot.
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, "t2");
    idle("t2 idle");
    chk("t2 first reg", write_reg, 3);
    idle("t2 idle2");
    chk("t2 second reg", write_reg, 4);
    idle("t2 drain");

    // Both producers held valid; the model predicts ALU backpressure.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(8 + i), 32'(100 + i), 1'b1, 5'(16 + i), 32'(200 + i), "sat");
    repeat (4) idle("sat drain");

    // Register 0 handshakes complete without occupying a slot.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, "r0");
    chk("r0 count", count, 0);
    query_reg = 5'd0;
    #1;
    chk("r0 query_hit", query_hit, 0);
    chk("r0 query_data", query_data, 0);
    #1;
    cycle(1'b1, 5'd0, 32'h77, 1'b1, 5'd9, 32'h99, "r0mix");
    repeat (2) idle("r0 drain");

    // Youngest pending write wins the lookup.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA, "q7a");
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB, "q7b");
    query_reg = 5'd7;
    #1;
    chk("q7 hit", query_hit, 1);
    chk("q7 data", query_data, 32'hB);
    #1;
    idle("q7 idle");
    chk("q7 output hit", query_hit, 1);
    chk("q7 output data", query_data, 32'hB);
    repeat (2) idle("q7 drain");
    chk("q7 retired hit", query_hit, 0);
    chk("q7 retired data", query_data, 0);

    // Asynchronous reset with three entries queued.
    cycle(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, "rs1");
    cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, "rs2");
    chk("rs queued", count, 3);
    rst = 1'b1;
    #1;
    chk("rs reg_write", reg_write, 0);
    chk("rs count", count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
    repeat (4) idle("rs after");

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle("final drain");
    chk("scoreboard empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
